// File: rtl/sha_host_ctrl.sv
// Host-side sequencer for the SHA-256 core: streams message bytes into the message
// SRAM, pulses go, waits for finish and streams the digest words back out.
module sha_host_ctrl #(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int OUTPUT_LENGTH      = 8,
    parameter int SYMBOL_WIDTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SYMBOL_WIDTH-1:0]               in_data,
    input  logic                                  in_last,
    output logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] host__msg__address,
    output logic [SYMBOL_WIDTH-1:0]               host__msg__write_data,
    output logic                                  host__msg__enable,
    output logic                                  host__msg__write,
    output logic                                  xxx__dut__go,
    output logic [$clog2(MAX_MESSAGE_LENGTH):0]   xxx__dut__msg_length,
    input  logic                                  dut__xxx__finish,
    output logic [$clog2(OUTPUT_LENGTH)-1:0]      host__dom__address,
    output logic                                  host__dom__enable,
    output logic                                  host__dom__write,
    input  logic [31:0]                           dom__host__data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [31:0]                           out_data,
    output logic                                  out_last,
    output logic                                  truncated,
    output logic                                  busy,
    output logic [2:0]                            dbg_state_o
);

    localparam int MSG_AW = $clog2(MAX_MESSAGE_LENGTH);
    localparam int CNT_W  = MSG_AW + 1;
    localparam int IDX_W  = $clog2(OUTPUT_LENGTH);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_MESSAGE_LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_LENGTH - 1);

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        GO       = 3'd1,
        WAIT_LOW = 3'd2,
        WAIT_FIN = 3'd3,
        RD       = 3'd4,
        CAP      = 3'd5,
        OUT      = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       msg_len_q, msg_len_d;
    logic                   trunc_q, trunc_d;
    logic                   msg_en_q, msg_en_d;
    logic [MSG_AW-1:0]      msg_addr_q, msg_addr_d;
    logic [SYMBOL_WIDTH-1:0] msg_wdata_q, msg_wdata_d;
    logic                   go_q, go_d;
    logic                   dom_en_q, dom_en_d;
    logic [IDX_W-1:0]       dom_addr_q, dom_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; in_ready depends only on state, out_valid/data/last hold until out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            msg_len_q   <= '0;
            trunc_q     <= 1'b0;
            msg_en_q    <= 1'b0;
            msg_addr_q  <= '0;
            msg_wdata_q <= '0;
            go_q        <= 1'b0;
            dom_en_q    <= 1'b0;
            dom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            msg_len_q   <= msg_len_d;
            trunc_q     <= trunc_d;
            msg_en_q    <= msg_en_d;
            msg_addr_q  <= msg_addr_d;
            msg_wdata_q <= msg_wdata_d;
            go_q        <= go_d;
            dom_en_q    <= dom_en_d;
            dom_addr_q  <= dom_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        msg_len_d   = msg_len_q;
        trunc_d     = trunc_q;
        msg_en_d    = 1'b0;
        msg_addr_d  = msg_addr_q;
        msg_wdata_d = msg_wdata_q;
        go_d        = 1'b0;
        dom_en_d    = 1'b0;
        dom_addr_d  = dom_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q < MAX_CNT) begin
                        msg_en_d    = 1'b1;
                        msg_addr_d  = cnt_q[MSG_AW-1:0];
                        msg_wdata_d = in_data;
                        cnt_d       = cnt_q + 1'b1;
                    end
                    // cnt_q == 0 marks the first byte of a message, which restarts the flag.
                    trunc_d = ((cnt_q == '0) ? 1'b0 : trunc_q) | (cnt_q >= MAX_CNT);
                    if (in_last) begin
                        msg_len_d = (cnt_q < MAX_CNT) ? cnt_q + 1'b1 : MAX_CNT;
                        cnt_d     = '0;
                        go_d      = 1'b1;
                        state_d   = GO;
                    end
                end
            end
            GO: state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!dut__xxx__finish) state_d = WAIT_FIN;
            end
            WAIT_FIN: begin
                if (dut__xxx__finish) begin
                    idx_d      = '0;
                    dom_en_d   = 1'b1;
                    dom_addr_d = '0;
                    state_d    = RD;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                out_data_d  = dom__host__data;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = LOAD;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        dom_en_d   = 1'b1;
                        dom_addr_d = idx_q + 1'b1;
                        state_d    = RD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready              = (state_q == LOAD);
    assign busy                  = (state_q != LOAD);
    assign host__msg__address    = msg_addr_q;
    assign host__msg__write_data = msg_wdata_q;
    assign host__msg__enable     = msg_en_q;
    assign host__msg__write      = msg_en_q;
    assign xxx__dut__go          = go_q;
    assign xxx__dut__msg_length  = msg_len_q;
    assign host__dom__address    = dom_addr_q;
    assign host__dom__enable     = dom_en_q;
    assign host__dom__write      = 1'b0;
    assign out_valid             = out_valid_q;
    assign out_data              = out_data_q;
    assign out_last              = out_last_q;
    assign truncated             = trunc_q;
    assign dbg_state_o           = state_q;

endmodule
